// File: rtl/acc_window_pkg.sv
// Shared register offsets, STATUS bit positions and engine states for the
// accelerator window responder.
package acc_window_pkg;

  // Register offsets relative to the window base (byte offsets, word aligned)
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DATA   = 8'h08;
  localparam logic [7:0] OFF_RESULT = 8'h0C;
  localparam logic [7:0] OFF_COEF   = 8'h10;
  localparam logic [7:0] OFF_LEN    = 8'h14;

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  // STATUS bits
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_FULL    = 3;
  localparam int ST_OVF     = 4;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acc_state_e;

endpackage

// File: rtl/acc_sync_fifo.sv
// Single-clock FIFO with show-ahead head output. Push when full and pop when
// empty are ignored. DEPTH must be a power of 2 and at least 2.
module acc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata_i;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards all contents
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acc_window_responder.sv
// Memory-mapped multiply-accumulate responder on an SRAM-style port.
// Core pushes operands into a FIFO, the engine accumulates head*COEF for LEN
// words, and the core reads RESULT/STATUS back with 1-cycle read latency.
module acc_window_responder
  import acc_window_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 15,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 15'h0400,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      we_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  acc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] coef_q, coef_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic [ADDR_WIDTH-1:0] off, off_w;
  logic                  in_win, wr, rd;
  logic                  sel_ctrl, sel_status, sel_data, sel_result, sel_coef, sel_len;
  logic                  start, clear, push, pop, busy;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head, status, rd_val;

  // Address decode: low two address bits are ignored by masking the offset
  assign off        = addr_i - BASE_ADDR;
  assign off_w      = off & ~ADDR_WIDTH'(3);
  assign in_win     = (addr_i >= BASE_ADDR);
  assign sel_ctrl   = in_win && (off_w == ADDR_WIDTH'(OFF_CTRL));
  assign sel_status = in_win && (off_w == ADDR_WIDTH'(OFF_STATUS));
  assign sel_data   = in_win && (off_w == ADDR_WIDTH'(OFF_DATA));
  assign sel_result = in_win && (off_w == ADDR_WIDTH'(OFF_RESULT));
  assign sel_coef   = in_win && (off_w == ADDR_WIDTH'(OFF_COEF));
  assign sel_len    = in_win && (off_w == ADDR_WIDTH'(OFF_LEN));

  assign wr    = en_i & we_i;
  assign rd    = en_i & ~we_i;
  assign start = wr & sel_ctrl & be_i[0] & wdata_i[CTRL_START];
  assign clear = wr & sel_ctrl & be_i[0] & wdata_i[CTRL_CLEAR];
  assign push  = wr & sel_data & (&be_i);
  assign busy  = (state_q == RUN);

  acc_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wdata_i),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // STATUS word assembly and read mux; unmapped offsets read as zero
  always_comb begin
    status                            = '0;
    status[ST_BUSY]                   = busy;
    status[ST_DONE]                   = done_q;
    status[ST_EMPTY]                  = fifo_empty;
    status[ST_FULL]                   = fifo_full;
    status[ST_OVF]                    = ovf_q;
    status[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
    rd_val = '0;
    if (sel_status)      rd_val = status;
    else if (sel_result) rd_val = result_q;
    else if (sel_coef)   rd_val = coef_q;
    else if (sel_len)    rd_val = DATA_WIDTH'(len_q);
    rdata_d = rd ? rd_val : rdata_q;
  end

  // Register writes, sticky flags and engine FSM next-state
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    coef_d   = coef_q;
    len_d    = len_q;
    rem_d    = rem_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    pop      = 1'b0;

    // Clear lands before start so a combined write restarts cleanly
    if (clear) begin
      ovf_d = 1'b0;
      if (!busy) done_d = 1'b0;
    end
    // An overflowing push is lost even if the engine pops this cycle
    if (push && fifo_full) ovf_d = 1'b1;

    if (!busy) begin
      if (wr && sel_coef)
        for (int i = 0; i < DATA_WIDTH/8; i++)
          if (be_i[i]) coef_d[8*i +: 8] = wdata_i[8*i +: 8];
      if (wr && sel_len)
        for (int i = 0; i < 2; i++)
          if (be_i[i]) len_d[8*i +: 8] = wdata_i[8*i +: 8];
    end

    case (state_q)
      RUN: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          result_d = result_q + fifo_head * coef_q;
          rem_d    = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      IDLE, DONE: begin
        // DONE is a one-cycle marker; done was raised on entry
        state_d = IDLE;
        if (start) begin
          result_d = '0;
          rem_d    = len_q;
          if (len_q == 16'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            done_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      result_q <= '0;
      coef_q   <= DATA_WIDTH'(1);
      len_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      result_q <= result_d;
      coef_q   <= coef_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = done_q;

endmodule

// File: tb/tb_acc_window_responder.sv
// Directed + randomized bench for acc_window_responder with a queue-based
// reference model of the FIFO and accumulate engine.
module tb_acc_window_responder;

  localparam logic [14:0] BASE   = 15'h0400;
  localparam logic [7:0]  O_CTRL = 8'h00;
  localparam logic [7:0]  O_STAT = 8'h04;
  localparam logic [7:0]  O_DATA = 8'h08;
  localparam logic [7:0]  O_RES  = 8'h0C;
  localparam logic [7:0]  O_COEF = 8'h10;
  localparam logic [7:0]  O_LEN  = 8'h14;
  localparam int          DEPTH  = 8;

  logic        clk, rst, en, we, irq;
  logic [14:0] addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  be;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [31:0] m_coef;
  logic [15:0] m_len;
  logic        m_ovf;
  logic [31:0] m_res, rv, v;
  logic [3:0]  b;

  acc_window_responder dut (
    .clk     (clk),
    .rst_i   (rst),
    .en_i    (en),
    .addr_i  (addr),
    .wdata_i (wdata),
    .we_i    (we),
    .be_i    (be),
    .rdata_o (rdata),
    .irq_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic busy_f, input logic done_f,
                                     input logic ovf_f, input int cnt);
    logic [31:0] s;
    s = 32'(cnt) << 8;
    s[0] = busy_f;
    s[1] = done_f;
    s[2] = (cnt == 0);
    s[3] = (cnt == DEPTH);
    s[4] = ovf_f;
    return s;
  endfunction

  task automatic wr_abs(input logic [14:0] a, input logic [31:0] d, input logic [3:0] bb);
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = a; wdata = d; be = bb;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] bb);
    wr_abs(BASE + 15'(o), d, bb);
  endtask

  task automatic rd_abs(input logic [14:0] a, output logic [31:0] d);
    @(negedge clk);
    en = 1'b1; we = 1'b0; addr = a; be = 4'h0; wdata = $urandom;
    @(negedge clk);
    en = 1'b0;
    d = rdata;
  endtask

  task automatic rd(input logic [7:0] o, output logic [31:0] d);
    rd_abs(BASE + 15'(o), d);
  endtask

  // Push a full word and mirror it in the model
  task automatic push(input logic [31:0] d);
    wr(O_DATA, d, 4'hF);
    if (q.size() < DEPTH) q.push_back(d);
    else m_ovf = 1'b1;
  endtask

  // Model of one completed run: accumulate the first LEN queued words
  function automatic logic [31:0] model_run(input int n);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < n; i++) acc = acc + q[i] * m_coef;
    return acc;
  endfunction

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) void'(q.pop_front());
  endtask

  task automatic wait_irq(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(irq), 32'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    m_coef = 32'd1; m_len = 16'd0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    // Reset state
    rd(O_STAT, rv); chk("rst_status", rv, st(0, 0, 0, 0));
    rd(O_COEF, rv); chk("rst_coef", rv, m_coef);
    rd(O_LEN, rv);  chk("rst_len", rv, 32'(m_len));
    rd(O_RES, rv);  chk("rst_result", rv, 32'd0);

    // Basic run: COEF=3, LEN=4, words 1..4
    wr(O_COEF, 32'd3, 4'hF); m_coef = 32'd3;
    wr(O_LEN, 32'd4, 4'hF);  m_len = 16'd4;
    for (int i = 1; i <= 4; i++) push(32'(i));
    rd(O_STAT, rv); chk("pre_start_status", rv, st(0, 0, 0, 4));
    wr(O_CTRL, 32'h1, 4'h1);
    m_res = model_run(4); pop_n(4);
    wait_irq(6, "run1_irq");
    rd(O_RES, rv);  chk("run1_result", rv, m_res);
    chk("run1_result_30", m_res, 32'd30);
    rd(O_STAT, rv); chk("run1_status", rv, st(0, 1, 0, 0));

    // Overflow: clear done, push 9 words
    wr(O_CTRL, 32'h2, 4'h1);
    rd(O_STAT, rv); chk("clear_status", rv, st(0, 0, 0, 0));
    for (int i = 0; i < 9; i++) push($urandom);
    rd(O_STAT, rv); chk("ovf_status", rv, st(0, 0, m_ovf, q.size()));
    wr(O_CTRL, 32'h2, 4'h1); m_ovf = 1'b0;
    rd(O_STAT, rv); chk("ovf_clear_status", rv, st(0, 0, 0, q.size()));

    // Drain the full FIFO with COEF=1, LEN=8
    wr(O_COEF, 32'd1, 4'hF); m_coef = 32'd1;
    wr(O_LEN, 32'd8, 4'h3);  m_len = 16'd8;
    wr(O_CTRL, 32'h1, 4'h1);
    m_res = model_run(8); pop_n(8);
    wait_irq(14, "drain_irq");
    rd(O_RES, rv); chk("drain_result", rv, m_res);
    wr(O_CTRL, 32'h2, 4'h1);

    // Stall on empty FIFO; start and COEF write while busy are ignored
    wr(O_COEF, 32'd2, 4'hF); m_coef = 32'd2;
    wr(O_LEN, 32'd2, 4'hF);  m_len = 16'd2;
    wr(O_CTRL, 32'h1, 4'h1);
    repeat (3) @(negedge clk);
    rd(O_STAT, rv); chk("stall_status", rv, st(1, 0, 0, 0));
    chk("stall_irq", 32'(irq), 32'd0);
    push(32'd5);
    wr(O_CTRL, 32'h1, 4'h1);
    wr(O_COEF, 32'd9, 4'hF);
    rd(O_COEF, rv); chk("busy_coef_write", rv, m_coef);
    push(32'd7);
    m_res = model_run(2); pop_n(2);
    wait_irq(6, "stall_irq_done");
    rd(O_RES, rv);  chk("stall_result", rv, m_res);
    chk("stall_result_24", m_res, 32'd24);
    rd(O_STAT, rv); chk("stall_done_status", rv, st(0, 1, 0, 0));

    // rdata holds when there is no read
    rd(O_COEF, rv);
    wr(O_LEN, 32'd0, 4'hF); m_len = 16'd0;
    @(negedge clk);
    chk("rdata_hold", rdata, m_coef);

    // LEN=0 with clear+start together: done right after the start edge
    wr(O_CTRL, 32'h3, 4'h1);
    chk("len0_irq", 32'(irq), 32'd1);
    rd(O_RES, rv);  chk("len0_result", rv, 32'd0);
    wr(O_DATA, 32'hDEAD, 4'h1);
    wr(O_DATA, 32'hBEEF, 4'h7);
    rd(O_STAT, rv); chk("partial_push_status", rv, st(0, 1, 0, q.size()));
    rd_abs(BASE + 15'h40, rv);  chk("unmapped_read", rv, 32'd0);
    rd_abs(BASE - 15'h4, rv);   chk("below_window_read", rv, 32'd0);
    rd(O_CTRL, rv);             chk("ctrl_reads_zero", rv, 32'd0);
    rd_abs(BASE + 15'h13, rv);  chk("coef_low_bits_ignored", rv, m_coef);

    // Reset during RUN with 3 words queued
    wr(O_CTRL, 32'h2, 4'h1);
    wr(O_LEN, 32'd5, 4'hF);
    for (int i = 0; i < 3; i++) wr(O_DATA, 32'(i + 9), 4'hF);
    wr(O_CTRL, 32'h1, 4'h1);
    rst = 1'b1;
    q.delete(); m_coef = 32'd1; m_len = 16'd0; m_ovf = 1'b0;
    @(negedge clk);
    chk("midrun_rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    chk("midrun_rst_irq", 32'(irq), 32'd0);
    rd(O_STAT, rv); chk("midrun_rst_status", rv, st(0, 0, 0, 0));
    rd(O_RES, rv);  chk("midrun_rst_result", rv, 32'd0);
    rd(O_COEF, rv); chk("midrun_rst_coef", rv, 32'd1);
    rd(O_LEN, rv);  chk("midrun_rst_len", rv, 32'd0);

    // Randomized runs: partial COEF writes, leftover words carried over
    for (int it = 0; it < 8; it++) begin
      int lo, hi, n;
      wr(O_CTRL, 32'h2, 4'h1);
      v = $urandom; b = 4'($urandom_range(0, 15));
      wr(O_COEF, v, b);
      for (int i = 0; i < 4; i++) if (b[i]) m_coef[8*i +: 8] = v[8*i +: 8];
      m_len = 16'($urandom_range(1, 6));
      wr(O_LEN, {16'($urandom), m_len}, 4'hF);
      rd(O_LEN, rv);  chk("rnd_len", rv, 32'(m_len));
      rd(O_COEF, rv); chk("rnd_coef", rv, m_coef);
      lo = (int'(m_len) > q.size()) ? int'(m_len) - q.size() : 0;
      hi = DEPTH - q.size();
      n  = $urandom_range(lo, hi);
      for (int i = 0; i < n; i++) push($urandom);
      wr(O_CTRL, 32'h1, 4'h1);
      m_res = model_run(int'(m_len)); pop_n(int'(m_len));
      wait_irq(20, "rnd_irq");
      rd(O_RES, rv);  chk("rnd_result", rv, m_res);
      rd(O_STAT, rv); chk("rnd_status", rv, st(0, 1, 0, q.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
